// File: rtl/fft_frame_loader.sv
// Drains one FRAME_LEN-sample frame from the shift FIFO into the FFT core once the FIFO reports full.
// Latency: a word read from the FIFO appears on out_data one cycle after its fifo_rd_ce cycle.
// Backpressure: out_ready low with out_valid high stalls reads and holds out_* stable; FIFO empty stalls and flags underrun.
module fft_frame_loader #(
  parameter int DWIDTH    = 32,
  parameter int FRAME_LEN = 128,
  parameter int IDX_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_rd_ce,
  output logic              start_fft,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              underrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // One extra bit so the count can reach FRAME_LEN without wrapping inside a frame.
  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(FRAME_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W:0]   rd_cnt;
  logic             load;
  logic             out_hs;
  logic             last_rd;
  logic             slot_free;

  assign out_hs    = out_valid & out_ready;
  assign last_rd   = (rd_cnt == LAST_CNT);
  // The output register can take a new word when it is empty or its word leaves this cycle.
  assign slot_free = ~out_valid | out_ready;

  assign fifo_rd_ce = load;
  assign busy       = (state != IDLE);

  // State register; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the combinational read enable and start pulse.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    start_fft = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_full) begin
          state_nxt = START;
        end
      end
      START: begin
        start_fft = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        load = slot_free & ~fifo_empty;
        if (load && last_rd) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register, read counter, frame counter and sticky underrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
      underrun  <= 1'b0;
    end else begin
      case (state)
        START: begin
          rd_cnt <= '0;
        end
        STREAM: begin
          if (load) begin
            out_data  <= fifo_data;
            out_valid <= 1'b1;
            out_index <= rd_cnt[IDX_W-1:0];
            out_last  <= last_rd;
            rd_cnt    <= rd_cnt + (IDX_W+1)'(1);
          end else begin
            if (out_hs) begin
              out_valid <= 1'b0;
            end
            // A read was wanted but the FIFO had nothing: remember it until reset.
            if (fifo_empty && slot_free) begin
              underrun <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: FIFO model around the DUT, frame-level reference model checked every cycle.
// Latency: model predicts each cycle's outputs from the inputs seen on the previous cycle.
// Backpressure: out_ready driven constant, patterned or random per test.
module tb_fft_frame_loader;

  localparam int DW = 32;
  localparam int FL = 128;
  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_ce;
  logic          start_fft;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          underrun;

  fft_frame_loader #(.DWIDTH(DW), .FRAME_LEN(FL), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_ce (fifo_rd_ce),
    .start_fft  (start_fft),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // FIFO model: circular store, shifted by the DUT's read enable, never cleared by reset.
  logic [DW-1:0] mem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            fifo_cnt;
  logic          hold_empty;

  always_comb begin
    fifo_cnt   = wr_ptr - rd_ptr;
    fifo_full  = (fifo_cnt >= FL) && !hold_empty;
    fifo_empty = (fifo_cnt == 0) || hold_empty;
    fifo_data  = mem[rd_ptr[7:0]];
  end

  always @(posedge clk) begin
    if (fifo_rd_ce && fifo_cnt > 0) rd_ptr <= rd_ptr + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: frame in progress, samples taken so far, and the word waiting at the output.
  bit            in_frame, start_now, mv, ml, urun;
  int            taken, mi;
  logic [DW-1:0] md;
  logic [15:0]   frames;

  // Measurements of DUT behaviour for the literal checks.
  int            cyc = 0, start_cnt = 0, last_cnt = 0, rd_in_frame = 0;
  int            start_cyc = 0, idle_cyc = 0, last_len = 0, start_gap = 0;
  bit            prev_busy = 0;
  logic [DW-1:0] acc_q [$];

  initial begin
    bit e_rd, hs;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_frame = 0; start_now = 0; mv = 0; ml = 0; urun = 0;
        taken = 0; mi = 0; md = '0; frames = '0; prev_busy = 0;
      end else begin
        e_rd = in_frame && !start_now && taken < FL && !fifo_empty && (!mv || out_ready);
        chk("start_fft", start_fft, start_now);
        chk("busy", busy, in_frame);
        chk("fifo_rd_ce", fifo_rd_ce, e_rd);
        chk("out_valid", out_valid, mv);
        chk("out_last", out_last, ml);
        if (mv) begin
          chk("out_data", out_data, md);
          chk("out_index", out_index, mi);
        end
        chk("frame_cnt", frame_cnt, frames);
        chk("underrun", underrun, urun);

        if (start_fft) begin
          start_cnt++;
          start_gap   = cyc - idle_cyc;
          start_cyc   = cyc;
          rd_in_frame = 0;
        end
        if (fifo_rd_ce) rd_in_frame++;
        if (prev_busy && !busy) begin
          idle_cyc = cyc;
          last_len = cyc - start_cyc;
        end
        prev_busy = busy;
        if (out_valid && out_ready) begin
          acc_q.push_back(out_data);
          if (out_last) last_cnt++;
        end

        hs = mv && out_ready;
        if (!in_frame) begin
          if (fifo_full) begin
            in_frame  = 1;
            start_now = 1;
          end
        end else if (start_now) begin
          start_now = 0;
          taken     = 0;
        end else if (e_rd) begin
          md = fifo_data;
          mi = taken;
          ml = (taken == FL - 1);
          mv = 1;
          taken++;
        end else begin
          if (taken < FL && fifo_empty && (!mv || out_ready)) urun = 1;
          if (hs) begin
            mv = 0;
            ml = 0;
            if (taken == FL) begin
              frames   = frames + 16'd1;
              in_frame = 0;
            end
          end
        end
      end
    end
  end

  // Stimulus helpers.
  int   rdy_mode = 0;
  int   tk = 0;
  logic pat [4];

  task automatic tick();
    @(posedge clk);
    #2;
    tk++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = pat[tk % 4];
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_frames(input int target, input string nm);
    for (int i = 0; i < 2000 && frame_cnt != 16'(target); i++) tick();
    chk(nm, frame_cnt, target);
  endtask

  task automatic wait_idx(input int idx, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (out_valid && out_index == IW'(idx)) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk(nm, ok, 1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_data"}, out_data, 0);
    chk({nm, "_out_index"}, out_index, 0);
    chk({nm, "_out_last"}, out_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_start"}, start_fft, 0);
    chk({nm, "_rd_ce"}, fifo_rd_ce, 0);
    chk({nm, "_frame_cnt"}, frame_cnt, 0);
    chk({nm, "_underrun"}, underrun, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] vals [FL];
    int base, s0, l0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b0; out_ready = 1'b0; hold_empty = 1'b0;

    // Reset applied between clock edges must clear everything at once.
    #1 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // Full frame with a counting pattern and constant ready.
    rdy_mode = 0;
    base = acc_q.size(); s0 = start_cnt; l0 = last_cnt;
    for (int i = 0; i < FL; i++) push(DW'(i));
    wait_frames(1, "t2_frame_cnt");
    tick();
    chk("t2_accepted", acc_q.size() - base, FL);
    for (int k = 0; k < FL; k++) chk("t2_data", acc_q[base + k], k);
    chk("t2_start_pulses", start_cnt - s0, 1);
    chk("t2_last_count", last_cnt - l0, 1);
    chk("t2_reads", rd_in_frame, FL);
    chk("t2_frame_cycles", last_len, FL + 2);

    // Backpressure pattern 1,0,0,1 with random data.
    rdy_mode = 1;
    base = acc_q.size();
    for (int i = 0; i < FL; i++) begin
      vals[i] = $urandom;
      push(vals[i]);
    end
    wait_frames(2, "t3_frame_cnt");
    tick();
    chk("t3_accepted", acc_q.size() - base, FL);
    for (int k = 0; k < FL; k++) chk("t3_data", acc_q[base + k], vals[k]);
    chk("t3_reads", rd_in_frame, FL);
    chk("t3_no_underrun", underrun, 0);

    // FIFO runs dry for 5 cycles once index 39 has been loaded.
    rdy_mode = 2;
    for (int i = 0; i < FL; i++) push($urandom);
    wait_idx(39, "t4_reach_idx39");
    rdy_mode = 0; out_ready = 1'b1; hold_empty = 1'b1;
    repeat (5) tick();
    hold_empty = 1'b0;
    rdy_mode = 2;
    wait_frames(3, "t4_frame_cnt");
    tick();
    chk("t4_underrun_sticky", underrun, 1);
    chk("t4_reads", rd_in_frame, FL);

    // Reset part-way through a frame; remaining FIFO words stay put.
    rdy_mode = 0;
    for (int i = 0; i < FL; i++) push($urandom);
    wait_idx(63, "t5_reach_idx63");
    #1 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(posedge clk);
    #2 rst = 1'b0;
    chk("t5_fifo_untouched", fifo_cnt, FL / 2);
    tick();
    for (int i = 0; i < FL / 2; i++) push($urandom);
    wait_idx(0, "t5_restart_idx0");
    wait_frames(1, "t5_frame_cnt");
    tick();
    chk("t5_reads", rd_in_frame, FL);

    // Back-to-back: FIFO refilled while the last sample is still draining.
    rdy_mode = 2;
    for (int i = 0; i < FL; i++) push($urandom);
    wait_idx(FL - 1, "t6_reach_last");
    for (int i = 0; i < FL; i++) push($urandom);
    wait_frames(2, "t6_first_frame");
    for (int i = 0; i < 10 && !busy; i++) tick();
    tick();
    chk("t6_restart_gap", start_gap, 1);
    wait_frames(3, "t6_frame_cnt");
    tick();
    chk("t6_reads", rd_in_frame, FL);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
